// File: rtl/core_pkg.sv
// Shared definitions for the 8-bit pipelined core.
// Contents: address/instruction widths, opcode field position, fetch FSM
// state encodings and a helper to extract the opcode from an instruction word.
package core_pkg;

    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned INSTR_W = 16;
    localparam int unsigned OPC_HI  = 15;
    localparam int unsigned OPC_LO  = 12;

    // Fetch FSM state encodings.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_BUBBLE = 2'd2;
    localparam logic [1:0] ST_HALTED = 2'd3;

    function automatic logic [3:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[OPC_HI:OPC_LO];
    endfunction

endpackage

// File: rtl/fseq_sat_counter.sv
// Saturating up-counter with enable; sticks at all-ones.
// Ports: clk, rst_n (async active-low), en (count when high),
//        count (current value, WIDTH bits).
module fseq_sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter and fetch controller. Drives the combinational instruction
// ROM address and captures the returned word into the IF/ID register.
// Optional macro: FSEQ_HALT_DETECT_EN enables HALT opcode detection and the
// HALTED state; without it halted is tied low.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start               pulse, leaves IDLE
//   stall               decode cannot accept; hold PC and IF/ID
//   redirect_valid/pc   taken branch/jump from execute
//   address             ROM address (= pc)
//   instruction         ROM read data, same cycle
//   if_instr/if_pc/if_valid  IF/ID register
//   running, halted     FSM status
//   fetch_count         saturating count of captured instructions
module fetch_sequencer
    import core_pkg::*;
#(
    parameter logic [7:0]  RESET_PC    = 8'h00,
    parameter logic [3:0]  HALT_OPCODE = 4'hF,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [7:0]       redirect_pc,
    output logic [7:0]       address,
    input  logic [15:0]      instruction,
    output logic [15:0]      if_instr,
    output logic [7:0]       if_pc,
    output logic             if_valid,
    output logic             running,
    output logic             halted,
    output logic [CNT_W-1:0] fetch_count
);

    logic [1:0]  state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [15:0] if_instr_q, if_instr_d;
    logic [7:0]  if_pc_q, if_pc_d;
    logic        if_valid_q, if_valid_d;
    logic        cnt_en;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        if_valid_d = if_valid_q;
        cnt_en     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if_valid_d = 1'b0;
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN, ST_BUBBLE: begin
                // Redirect wins over stall: the stalled IF/ID word is on the
                // wrong path anyway.
                if (redirect_valid) begin
                    pc_d       = redirect_pc;
                    if_valid_d = 1'b0;
                    state_d    = ST_BUBBLE;
                end else if (!stall) begin
                    if_instr_d = instruction;
                    if_pc_d    = pc_q;
                    if_valid_d = 1'b1;
                    pc_d       = pc_q + 8'd1;
                    cnt_en     = 1'b1;
                    state_d    = ST_RUN;
`ifdef FSEQ_HALT_DETECT_EN
                    if ((state_q == ST_RUN) && (opcode_of(instruction) == HALT_OPCODE)) begin
                        state_d = ST_HALTED;
                    end
`endif
                end
            end
`ifdef FSEQ_HALT_DETECT_EN
            ST_HALTED: begin
                if_valid_d = 1'b0;
            end
`endif
            default: begin
                state_d    = ST_IDLE;
                if_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            if_instr_q <= 16'h0000;
            if_pc_q    <= 8'h00;
            if_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
            if_valid_q <= if_valid_d;
        end
    end

    fseq_sat_counter #(
        .WIDTH(CNT_W)
    ) u_fetch_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (cnt_en),
        .count(fetch_count)
    );

    assign address  = pc_q;
    assign if_instr = if_instr_q;
    assign if_pc    = if_pc_q;
    assign if_valid = if_valid_q;
    assign running  = (state_q == ST_RUN) || (state_q == ST_BUBBLE);

`ifdef FSEQ_HALT_DETECT_EN
    assign halted = (state_q == ST_HALTED);
`else
    logic unused_halt_opcode;
    assign unused_halt_opcode = ^HALT_OPCODE;
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: a ROM model feeds the DUT, expected
// IF/ID captures are queued as stimulus is issued and popped as captures appear.
module tb_fetch_sequencer;

    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             stall;
    logic             redirect_valid;
    logic [7:0]       redirect_pc;
    logic [7:0]       address;
    logic [15:0]      instruction;
    logic [15:0]      if_instr;
    logic [7:0]       if_pc;
    logic             if_valid;
    logic             running;
    logic             halted;
    logic [CNT_W-1:0] fetch_count;

    logic [15:0] rom [256];
    logic [23:0] exp_q [$];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    assign instruction = rom[address];

    fetch_sequencer #(
        .RESET_PC   (8'h00),
        .HALT_OPCODE(4'hF),
        .CNT_W      (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .address       (address),
        .instruction   (instruction),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .if_valid      (if_valid),
        .running       (running),
        .halted        (halted),
        .fetch_count   (fetch_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] pc);
        logic [15:0] w;
        w = rom[pc];
        exp_q.push_back({pc, w});
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    // A fresh capture is any valid IF/ID that was not simply held by a stall.
    task automatic step(input logic st, input logic sl, input logic rv, input logic [7:0] rpc);
        logic [23:0] e;
        start          = st;
        stall          = sl;
        redirect_valid = rv;
        redirect_pc    = rpc;
        @(posedge clk);
        #1;
        if (if_valid && !(sl && !rv)) begin
            check_eq("sb_avail", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_eq("sb_pc", 32'(if_pc), 32'(e[23:16]));
                check_eq("sb_instr", 32'(if_instr), 32'(e[15:0]));
            end
        end
        start          = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 8'h00;
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_addr"}, 32'(address), 32'h00);
        check_eq({tag, "_valid"}, 32'(if_valid), 32'd0);
        check_eq({tag, "_instr"}, 32'(if_instr), 32'h0000);
        check_eq({tag, "_ifpc"}, 32'(if_pc), 32'h00);
        check_eq({tag, "_running"}, 32'(running), 32'd0);
        check_eq({tag, "_halted"}, 32'(halted), 32'd0);
        check_eq({tag, "_count"}, 32'(fetch_count), 32'd0);
    endtask

    // Reset asserted between edges; outputs must clear without a clock edge.
    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals(tag);
        exp_q.delete();
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            rom[i] = {8'h20, 8'(i)};
        end
        rom[0] = 16'h1001;
        rom[1] = 16'h2002;
        rom[2] = 16'h3003;
        rom[3] = 16'hF000;

        rst_n          = 1'b0;
        start          = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 8'h00;
        #3;
        check_reset_vals("por");
        #9;
        rst_n = 1'b1;

        // Inputs other than start are ignored in IDLE.
        step(1'b0, 1'b0, 1'b1, 8'h33);
        check_eq("idle_addr", 32'(address), 32'h00);
        check_eq("idle_running", 32'(running), 32'd0);

        step(1'b1, 1'b0, 1'b0, 8'h00);
        check_eq("start_running", 32'(running), 32'd1);
        check_eq("start_valid", 32'(if_valid), 32'd0);
        check_eq("start_addr", 32'(address), 32'h00);

        for (int i = 0; i < 3; i++) begin
            push_exp(8'(i));
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 8'h00);
        end
        check_eq("seq_count", 32'(fetch_count), 32'd3);
        check_eq("sb_drain_seq", 32'(exp_q.size()), 32'd0);

`ifdef FSEQ_HALT_DETECT_EN
        push_exp(8'h03);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        check_eq("halt_cap_valid", 32'(if_valid), 32'd1);
        check_eq("halt_flag", 32'(halted), 32'd1);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        check_eq("halt_valid", 32'(if_valid), 32'd0);
        check_eq("halt_addr", 32'(address), 32'h04);
        check_eq("halt_running", 32'(running), 32'd0);
        step(1'b1, 1'b0, 1'b1, 8'h40);
        step(1'b1, 1'b1, 1'b0, 8'h00);
        check_eq("halt_hold_addr", 32'(address), 32'h04);
        check_eq("halt_hold_flag", 32'(halted), 32'd1);
        check_eq("halt_hold_count", 32'(fetch_count), 32'd4);
        async_reset("halt_rst");
        rom[3] = 16'h2003;
        step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) begin
            push_exp(8'(i));
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b0, 8'h00);
        end
`else
        // Without halt detection the 0xF opcode is an ordinary word.
        push_exp(8'h03);
        push_exp(8'h04);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        check_eq("nohalt_flag", 32'(halted), 32'd0);
        check_eq("nohalt_running", 32'(running), 32'd1);
`endif
        check_eq("pre_stall_addr", 32'(address), 32'h05);
        check_eq("pre_stall_count", 32'(fetch_count), 32'd5);

        // Stall for three cycles at pc=5.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 8'h00);
            check_eq("stall_addr", 32'(address), 32'h05);
            check_eq("stall_ifpc", 32'(if_pc), 32'h04);
            check_eq("stall_count", 32'(fetch_count), 32'd5);
        end
        push_exp(8'h05);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        check_eq("post_stall_count", 32'(fetch_count), 32'd6);

        // Redirect during stall.
        step(1'b0, 1'b1, 1'b1, 8'h40);
        check_eq("redir_valid", 32'(if_valid), 32'd0);
        check_eq("redir_addr", 32'(address), 32'h40);
        check_eq("redir_running", 32'(running), 32'd1);
        // Stall in the bubble holds the target.
        step(1'b0, 1'b1, 1'b0, 8'h00);
        check_eq("bubble_stall_valid", 32'(if_valid), 32'd0);
        check_eq("bubble_stall_addr", 32'(address), 32'h40);
        push_exp(8'h40);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        check_eq("redir_cap_addr", 32'(address), 32'h41);
        check_eq("redir_count", 32'(fetch_count), 32'd7);

        // Wrap from 0xFE through 0x00.
        step(1'b0, 1'b0, 1'b1, 8'hFE);
        push_exp(8'hFE);
        push_exp(8'hFF);
        push_exp(8'h00);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 8'h00);
            check_eq("wrap_valid", 32'(if_valid), 32'd1);
        end
        check_eq("wrap_addr", 32'(address), 32'h01);
        check_eq("wrap_count", 32'(fetch_count), 32'd10);
        check_eq("sb_drain_wrap", 32'(exp_q.size()), 32'd0);

        // Mid-run async reset; start is required again.
        push_exp(8'h01);
        async_reset("mid_rst");
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        check_eq("rst_idle_addr", 32'(address), 32'h00);
        check_eq("rst_idle_valid", 32'(if_valid), 32'd0);
        check_eq("rst_idle_running", 32'(running), 32'd0);

        // Restart and run past the counter's saturation point.
        step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 20; i++) begin
            push_exp(8'(i));
            step(1'b0, 1'b0, 1'b0, 8'h00);
            check_eq("sat_count", 32'(fetch_count), (i + 1 > 15) ? 32'd15 : 32'(i + 1));
        end
        check_eq("sat_addr", 32'(address), 32'd20);
        check_eq("sb_drain_end", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
